// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state, opcode, funct and control-field encodings for mc_ctrl_fsm
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_HALTED = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM    = 4'd4,
    ST_WB     = 4'd5,
    ST_FAULT  = 4'd6
  } state_t;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // alu_op field
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGI  = 2'b11;

  // alu_src_b field
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // pc_src field
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // R-type funct codes the datapath implements; everything else faults.
  function automatic logic rfunct_legal(input logic [5:0] funct);
    case (funct)
      FN_JR, FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: rfunct_legal = 1'b1;
      default:                                        rfunct_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_timeout.sv
// rtl/mc_ctrl_fsm_timeout.sv - memory-wait timeout counter (module mc_timeout)
module mc_timeout #(
  parameter int TIMEOUT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  // Value one below all-ones: the wait cycle seen here is the one that reaches the limit.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] cnt_q;

  // Count stalled memory cycles; any state change restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = inc && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle CPU control FSM; MC_CTRL_BRANCH_EN adds BEQ/BNE/J and zero_inv
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ior_d,
  output logic        ir_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        imm_zext,
  output logic [1:0]  alu_op,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        active,
  output logic        fault,
  output logic [3:0]  state_o
`ifdef MC_CTRL_BRANCH_EN
  ,
  output logic        zero_inv
`endif
);

  state_t state_q, state_d;
  logic   to_clr, to_inc, to_expired;

  logic [5:0] opcode, funct;
  logic       is_rtype, is_jr, is_lw, is_sw, is_addiu, is_logi, legal;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[20:6];

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_addiu = (opcode == OP_ADDIU);
  assign is_logi  = (opcode == OP_ANDI) || (opcode == OP_ORI);

`ifdef MC_CTRL_BRANCH_EN
  logic is_beq, is_bne, is_j;
  assign is_beq = (opcode == OP_BEQ);
  assign is_bne = (opcode == OP_BNE);
  assign is_j   = (opcode == OP_J);
  assign legal  = (is_rtype && rfunct_legal(funct)) || is_lw || is_sw || is_addiu ||
                  is_logi || is_beq || is_bne || is_j;
`else
  assign legal  = (is_rtype && rfunct_legal(funct)) || is_lw || is_sw || is_addiu || is_logi;
`endif

  // Only FETCH and MEM talk to memory, so mem_ready elsewhere never counts as a stall.
  assign to_inc = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
  assign to_clr = (state_d != state_q);

  mc_timeout #(.TIMEOUT_W(TIMEOUT_W)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (to_clr),
    .inc     (to_inc),
    .expired (to_expired)
  );

  // State register; reset drops straight to HALTED even mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HALTED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; every control defaults low.
  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ior_d         = 1'b0;
    ir_write      = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    imm_zext      = 1'b0;
    alu_op        = ALU_ADD;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PCSRC_ALU;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    fault         = 1'b0;
`ifdef MC_CTRL_BRANCH_EN
    zero_inv      = 1'b0;
`endif
    case (state_q)
      ST_HALTED: if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (to_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        state_d   = legal ? ST_EXEC : ST_FAULT;
      end
      ST_EXEC: begin
        if (is_jr) begin
          if (instr[25:21] == 5'd0) begin
            state_d = ST_HALTED;
          end else begin
            alu_src_a = 1'b1;
            pc_write  = 1'b1;
            pc_src    = PCSRC_ALUOUT;
            state_d   = ST_FETCH;
          end
        end else if (is_rtype) begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
          state_d   = ST_WB;
        end else if (is_lw || is_sw) begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = ST_MEM;
        end else if (is_addiu || is_logi) begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = is_logi ? ALU_LOGI : ALU_ADD;
          imm_zext  = is_logi;
          state_d   = ST_WB;
`ifdef MC_CTRL_BRANCH_EN
        end else if (is_beq || is_bne) begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = PCSRC_ALUOUT;
          zero_inv      = is_bne;
          state_d       = ST_FETCH;
        end else if (is_j) begin
          pc_write = 1'b1;
          pc_src   = PCSRC_JUMP;
          state_d  = ST_FETCH;
`endif
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        ior_d   = 1'b1;
        mem_we  = is_sw;
        if (mem_ready) begin
          state_d = is_sw ? ST_FETCH : ST_WB;
        end else if (to_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype;
        mem_to_reg = is_lw;
        state_d    = ST_FETCH;
      end
      ST_FAULT: fault = 1'b1;
      default:  state_d = ST_FAULT;
    endcase
  end

  assign active  = (state_q != ST_HALTED) && (state_q != ST_FAULT);
  assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - table-driven bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

  localparam logic [3:0] S_H = 4'd0, S_F = 4'd1, S_D = 4'd2, S_E = 4'd3,
                         S_M = 4'd4, S_W = 4'd5, S_X = 4'd6;

  // Control word bit positions, MSB first as packed into ctl below.
  localparam logic [18:0] C_REQ  = 19'h1 << 18, C_WE    = 19'h1 << 17, C_IORD = 19'h1 << 16,
                          C_IRW  = 19'h1 << 15, C_SRCA  = 19'h1 << 14, C_SB4  = 19'h1 << 12,
                          C_SBI  = 19'h2 << 12, C_SBI2  = 19'h3 << 12, C_ZEXT = 19'h1 << 11,
                          C_OSUB = 19'h1 << 9,  C_OFN   = 19'h2 << 9,  C_OLOG = 19'h3 << 9,
                          C_PCW  = 19'h1 << 8,  C_PCWC  = 19'h1 << 7,  C_PSAO = 19'h1 << 5,
                          C_RW   = 19'h1 << 4,  C_RDST  = 19'h1 << 3,  C_M2R  = 19'h1 << 2,
                          C_ACT  = 19'h1 << 1,  C_FLT   = 19'h1;
  localparam logic [18:0] FETCH_OK = C_REQ | C_SB4 | C_IRW | C_PCW | C_ACT;
  localparam logic [18:0] DEC      = C_SBI2 | C_ACT;

  logic        clk, rst_n, run, mem_ready;
  logic [31:0] instr;
  logic        mem_req, mem_we, ior_d, ir_write, alu_src_a, imm_zext;
  logic        pc_write, pc_write_cond, reg_write, reg_dst, mem_to_reg, active, fault;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state_o;
  logic [18:0] ctl;
`ifdef MC_CTRL_BRANCH_EN
  logic        zero_inv;
`endif

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic        rst_n;
    logic        run;
    logic [31:0] instr;
    logic        rdy;
    logic [3:0]  st;
    logic [18:0] ctl;
  } vec_t;
  vec_t vecs[$];

  mc_ctrl_fsm #(.TIMEOUT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ior_d(ior_d), .ir_write(ir_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_op(alu_op),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .active(active), .fault(fault), .state_o(state_o)
`ifdef MC_CTRL_BRANCH_EN
    , .zero_inv(zero_inv)
`endif
  );

  assign ctl = {mem_req, mem_we, ior_d, ir_write, alu_src_a, alu_src_b, imm_zext, alu_op,
                pc_write, pc_write_cond, pc_src, reg_write, reg_dst, mem_to_reg, active, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic r, input logic ru, input logic [31:0] i, input logic rd,
                     input logic [3:0] st, input logic [18:0] c);
    vec_t v;
    v.rst_n = r; v.run = ru; v.instr = i; v.rdy = rd; v.st = st; v.ctl = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] st, input logic [18:0] c);
    tests++;
    if (state_o !== st || ctl !== c) begin
      failed++;
      $display("FAIL %s state=%0d expected %0d ctl=%h expected %h", name, state_o, st, ctl, c);
    end
  endtask

  // One cycle: drive at the falling edge, sample 1 ns later.
  task automatic apply(input string name, input logic r, input logic ru, input logic [31:0] i,
                       input logic rd, input logic [3:0] st, input logic [18:0] c);
    @(negedge clk);
    rst_n = r; run = ru; instr = i; mem_ready = rd;
    #1;
    check(name, st, c);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; run = 1'b0; instr = '0; mem_ready = 1'b1;

    // Reset and start
    add(0, 0, 32'h0, 1, S_H, '0);
    add(1, 0, 32'h0, 1, S_H, '0);
    add(1, 1, 32'h0, 1, S_H, '0);
    // ADDU, zero wait: 4 cycles
    add(1, 0, 32'h00221821, 1, S_F, FETCH_OK);
    add(1, 0, 32'h00221821, 1, S_D, DEC);
    add(1, 0, 32'h00221821, 1, S_E, C_SRCA | C_OFN | C_ACT);
    add(1, 0, 32'h00221821, 1, S_W, C_RW | C_RDST | C_ACT);
    // LW with two wait cycles in MEM: 7 cycles
    add(1, 0, 32'h8C220004, 1, S_F, FETCH_OK);
    add(1, 0, 32'h8C220004, 1, S_D, DEC);
    add(1, 0, 32'h8C220004, 1, S_E, C_SRCA | C_SBI | C_ACT);
    add(1, 0, 32'h8C220004, 0, S_M, C_REQ | C_IORD | C_ACT);
    add(1, 0, 32'h8C220004, 0, S_M, C_REQ | C_IORD | C_ACT);
    add(1, 0, 32'h8C220004, 1, S_M, C_REQ | C_IORD | C_ACT);
    add(1, 0, 32'h8C220004, 1, S_W, C_RW | C_M2R | C_ACT);
    // SW with one fetch wait
    add(1, 0, 32'hAC220004, 0, S_F, C_REQ | C_SB4 | C_ACT);
    add(1, 0, 32'hAC220004, 1, S_F, FETCH_OK);
    add(1, 0, 32'hAC220004, 1, S_D, DEC);
    add(1, 0, 32'hAC220004, 1, S_E, C_SRCA | C_SBI | C_ACT);
    add(1, 0, 32'hAC220004, 1, S_M, C_REQ | C_IORD | C_WE | C_ACT);
    // ANDI
    add(1, 0, 32'h3022000F, 1, S_F, FETCH_OK);
    add(1, 0, 32'h3022000F, 1, S_D, DEC);
    add(1, 0, 32'h3022000F, 1, S_E, C_SRCA | C_SBI | C_ZEXT | C_OLOG | C_ACT);
    add(1, 0, 32'h3022000F, 1, S_W, C_RW | C_ACT);
    // ADDIU with mem_ready low where it must be ignored
    add(1, 0, 32'h24220005, 1, S_F, FETCH_OK);
    add(1, 0, 32'h24220005, 0, S_D, DEC);
    add(1, 0, 32'h24220005, 0, S_E, C_SRCA | C_SBI | C_ACT);
    add(1, 0, 32'h24220005, 0, S_W, C_RW | C_ACT);
    // JR $1: 3 cycles
    add(1, 0, 32'h00200008, 1, S_F, FETCH_OK);
    add(1, 0, 32'h00200008, 1, S_D, DEC);
    add(1, 0, 32'h00200008, 1, S_E, C_SRCA | C_PCW | C_PSAO | C_ACT);
    // JR $0 halts
    add(1, 0, 32'h00000008, 1, S_F, FETCH_OK);
    add(1, 0, 32'h00000008, 1, S_D, DEC);
    add(1, 0, 32'h00000008, 1, S_E, C_ACT);
    add(1, 0, 32'h00000008, 1, S_H, '0);
    add(1, 1, 32'h00000008, 1, S_H, '0);
    // Opcode 0x3F faults; run ignored in FAULT
    add(1, 0, 32'hFC000000, 1, S_F, FETCH_OK);
    add(1, 0, 32'hFC000000, 1, S_D, DEC);
    add(1, 1, 32'hFC000000, 1, S_X, C_FLT);
    add(1, 1, 32'hFC000000, 0, S_X, C_FLT);
    add(0, 0, 32'h0, 1, S_H, '0);
    add(1, 1, 32'h0, 1, S_H, '0);
    // BEQ
    add(1, 0, 32'h10220003, 1, S_F, FETCH_OK);
    add(1, 0, 32'h10220003, 1, S_D, DEC);
`ifdef MC_CTRL_BRANCH_EN
    add(1, 0, 32'h10220003, 1, S_E, C_SRCA | C_OSUB | C_PCWC | C_PSAO | C_ACT);
    add(1, 0, 32'h10220003, 1, S_F, FETCH_OK);
`else
    add(1, 0, 32'h10220003, 1, S_X, C_FLT);
    add(1, 0, 32'h10220003, 1, S_X, C_FLT);
`endif

    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].run, vecs[i].instr, vecs[i].rdy,
            vecs[i].st, vecs[i].ctl);

    // Fetch timeout with TIMEOUT_W=3: seven stalled cycles, then FAULT
    apply("to_rst", 0, 0, 32'h0, 1, S_H, '0);
    apply("to_run", 1, 1, 32'h0, 0, S_H, '0);
    apply("to_fetch", 1, 0, 32'h0, 0, S_F, C_REQ | C_SB4 | C_ACT);
    n = 1;
    while (state_o == S_F && n < 20) begin
      @(negedge clk);
      #1;
      if (state_o == S_F) n++;
    end
    tests++;
    if (n != 7) begin
      failed++;
      $display("FAIL to_wait_cycles got %0d expected 7", n);
    end
    check("to_fault", S_X, C_FLT);
    apply("to_sticky", 1, 1, 32'h0, 1, S_X, C_FLT);
    apply("to_sticky2", 1, 1, 32'h0, 0, S_X, C_FLT);
    apply("to_clear", 0, 0, 32'h0, 1, S_H, '0);

    // Asynchronous reset in the middle of an SW memory access
    apply("sw_run", 1, 1, 32'h0, 1, S_H, '0);
    apply("sw_f", 1, 0, 32'hAC220004, 1, S_F, FETCH_OK);
    apply("sw_d", 1, 0, 32'hAC220004, 1, S_D, DEC);
    apply("sw_e", 1, 0, 32'hAC220004, 1, S_E, C_SRCA | C_SBI | C_ACT);
    apply("sw_m", 1, 0, 32'hAC220004, 0, S_M, C_REQ | C_IORD | C_WE | C_ACT);
    #2;
    rst_n = 1'b0;
    #1;
    check("sw_async_rst", S_H, '0);
    tests++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      failed++;
      $display("FAIL sw_strobes mem_req=%b mem_we=%b expected 0 0", mem_req, mem_we);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_W, default 4, width of the memory-wait timeout counter (legal 2..16).
REQ-002 The block SHALL have ports, clock and reset first:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  reset, asynchronous, active-low
 run  in  1  start request from HALTED
 instr  in  32  current IR contents
 mem_ready  in  1  memory completes the access this cycle
 mem_req  out  1  memory access request
 mem_we  out  1  memory write strobe (valid with mem_req)
 ior_d  out  1  address select: 0 = PC, 1 = ALUOut
 ir_write  out  1  load IR
 alu_src_a  out  1  0 = PC, 1 = reg A
 alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = imm, 11 = imm<<2
 imm_zext  out  1  immediate zero-extended when 1, sign-extended when 0
 alu_op  out  2  00 add, 01 sub, 10 funct-decoded, 11 logic-imm
 pc_write  out  1  unconditional PC load
 pc_write_cond  out  1  PC load gated by ALU zero
 pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
 reg_write  out  1  register file write
 reg_dst  out  1  0 = rt, 1 = rd
 mem_to_reg  out  1  0 = ALUOut, 1 = MDR
 active  out  1  high in every state except HALTED and FAULT
 fault  out  1  sticky error flag
 state_o  out  4  current state encoding

Function
REQ-003 States SHALL be HALTED, FETCH, DECODE, EXEC, MEM, WB, FAULT; every output not listed for a state SHALL be 0.
REQ-004 HALTED -> FETCH when run=1; otherwise hold.
REQ-005 FETCH: mem_req=1, ior_d=0, alu_src_a=0, alu_src_b=01, alu_op=00; when mem_ready=1, ir_write=1, pc_write=1, pc_src=00, next DECODE; else hold.
REQ-006 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next EXEC for a legal opcode, FAULT otherwise.
REQ-007 Legal opcodes: R-type (funct ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, SLT 0x2A, JR 0x08), LW 0x23, SW 0x2B, ADDIU 0x09, ANDI 0x0C, ORI 0x0D; any other opcode or R-type funct SHALL go to FAULT.
REQ-008 EXEC R-type: alu_src_a=1, alu_src_b=00, alu_op=10, next WB; WB: reg_dst=1, mem_to_reg=0, reg_write=1, next FETCH.
REQ-009 EXEC JR: if instr[25:21]==0 next HALTED, else pc_write=1, pc_src=01 with alu_src_a=1, alu_op=00, next FETCH.
REQ-010 EXEC LW/SW: alu_src_a=1, alu_src_b=10, alu_op=00, next MEM; MEM: mem_req=1, ior_d=1, mem_we=1 for SW only; on mem_ready LW -> WB, SW -> FETCH.
REQ-011 LW WB: reg_dst=0, mem_to_reg=1, reg_write=1, next FETCH.
REQ-012 EXEC ADDIU/ANDI/ORI: alu_src_a=1, alu_src_b=10, alu_op=00 (ADDIU) or 11 (ANDI/ORI), imm_zext=1 for ANDI/ORI; next WB with reg_dst=0, mem_to_reg=0, reg_write=1.
REQ-013 Zero-wait latency SHALL be R/imm 4, LW 5, SW 4, JR 3 cycles; each mem_ready-low cycle adds exactly one cycle.
REQ-014 Timeout counter SHALL clear on entry to FETCH/MEM, increment each cycle mem_req=1 and mem_ready=0, and on reaching 2^TIMEOUT_W-1 force next state FAULT.
REQ-015 FAULT SHALL assert fault=1 and hold until reset; run SHALL be ignored there.
REQ-016 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-017 rst_n=0 SHALL asynchronously force HALTED, clear timeout counter and fault; all outputs 0, including mid-access.

Configuration
REQ-018 With MC_CTRL_BRANCH_EN defined: BEQ 0x04, BNE 0x05 (EXEC: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, 3 cycles; BNE inverts zero via a zero_inv output) and J 0x02 (EXEC: pc_write=1, pc_src=10, 3 cycles) SHALL be legal; without it those opcodes SHALL FAULT and zero_inv SHALL not exist.

Structure
REQ-019 Opcode, funct, state and alu_op/alu_src_b encodings SHALL live in package mc_ctrl_pkg.
REQ-020 The timeout counter SHALL be sub-module mc_timeout (parameter TIMEOUT_W; inputs clr, inc; output expired).

Verification
REQ-021 ADDU instr=0x00221821, mem_ready=1 constant -> state path FETCH,DECODE,EXEC,WB; reg_write=1, reg_dst=1 in cycle 4.
REQ-022 LW instr=0x8C220004, mem_ready low 2 cycles in MEM -> 7 cycles total, reg_write=1 mem_to_reg=1 in last.
REQ-023 TIMEOUT_W=3, mem_ready held 0 in FETCH -> FAULT after 7 wait cycles, fault=1 until rst_n.
REQ-024 Opcode 0x3F -> FAULT from DECODE; JR $0 (0x00000008) -> HALTED, active=0.
REQ-025 rst_n low during MEM of SW -> mem_req, mem_we drop immediately, state HALTED.
REQ-026 BEQ 0x10220003 -> pc_write_cond=1 in cycle 3 with macro; FAULT without macro.
